idex_operand_stage: RTL and testbench

- Pipeline register that sits directly upstream of the integer ALU.
- Captures decoded instruction fields and selects the two ALU operands (rs1 or PC, rs2 or immediate). Presents op1/op2/alu_op plus writeback and branch tags to the execute stage under a valid/ready handshake.
- Supports stall (backpressure), flush (branch redirect) and a saturating stall-cycle counter.

---
 rtl/idex_operand_stage.sv | 162 ++++++++++++++++
 tb/tb_idex_operand_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/idex_operand_stage.sv
// ID/EX operand stage: captures decoded fields, selects ALU operands, handles stall/flush and counts stalls.
// Optional writeback forwarding into the captured/held operands is enabled by defining IDEX_WB_FWD_EN.
module idex_operand_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [4:0]       in_rs1_addr,
  input  logic [4:0]       in_rs2_addr,
  input  logic [4:0]       in_rd_addr,
  input  logic             in_op1_sel,
  input  logic             in_op2_sel,
  input  logic [3:0]       in_alu_op,
  input  logic [2:0]       in_br_type,
  input  logic             in_rd_wen,
  input  logic             flush,
  input  logic             wb_wen,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [3:0]       alu_op,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_store_data,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rd_addr,
  output logic             out_rd_wen,
  output logic [2:0]       out_br_type,
  output logic [CNT_W-1:0] stall_cnt
);

  logic            accept_s;
  logic            hold_s;
  logic [XLEN-1:0] rs1val_s;
  logic [XLEN-1:0] rs2val_s;
  logic [XLEN-1:0] op1_nxt_s;
  logic [XLEN-1:0] op2_nxt_s;
  logic [XLEN-1:0] sd_nxt_s;

  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready && !flush;
  assign hold_s   = out_valid && !out_ready && !flush;

`ifdef IDEX_WB_FWD_EN
  logic [4:0] rs1_addr_r;
  logic [4:0] rs2_addr_r;
  logic       op1_sel_r;
  logic       op2_sel_r;
  logic       fwd1_s;
  logic       fwd2_s;
  logic       hfwd1_s;
  logic       hfwd2_s;

  // Operand values with writeback forwarding at capture and onto the held payload
  always_comb begin
    fwd1_s   = wb_wen && (wb_rd == in_rs1_addr) && (in_rs1_addr != 5'd0);
    fwd2_s   = wb_wen && (wb_rd == in_rs2_addr) && (in_rs2_addr != 5'd0);
    hfwd1_s  = hold_s && wb_wen && (wb_rd == rs1_addr_r) && (rs1_addr_r != 5'd0);
    hfwd2_s  = hold_s && wb_wen && (wb_rd == rs2_addr_r) && (rs2_addr_r != 5'd0);
    rs1val_s = fwd1_s ? wb_data : in_rs1_data;
    rs2val_s = fwd2_s ? wb_data : in_rs2_data;
    if (accept_s) begin
      op1_nxt_s = in_op1_sel ? in_pc : rs1val_s;
      op2_nxt_s = in_op2_sel ? in_imm : rs2val_s;
      sd_nxt_s  = rs2val_s;
    end else begin
      op1_nxt_s = (hfwd1_s && !op1_sel_r) ? wb_data : op1;
      op2_nxt_s = (hfwd2_s && !op2_sel_r) ? wb_data : op2;
      sd_nxt_s  = hfwd2_s ? wb_data : out_store_data;
    end
  end

  // Source addresses and selects kept so a held instruction can still be forwarded into
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_addr_r <= 5'd0;
      rs2_addr_r <= 5'd0;
      op1_sel_r  <= 1'b0;
      op2_sel_r  <= 1'b0;
    end else if (accept_s) begin
      rs1_addr_r <= in_rs1_addr;
      rs2_addr_r <= in_rs2_addr;
      op1_sel_r  <= in_op1_sel;
      op2_sel_r  <= in_op2_sel;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{wb_wen, wb_rd, wb_data, in_rs1_addr, in_rs2_addr};

  // Operand values straight from the register file; decode interlocks on hazards
  always_comb begin
    rs1val_s = in_rs1_data;
    rs2val_s = in_rs2_data;
    if (accept_s) begin
      op1_nxt_s = in_op1_sel ? in_pc : rs1val_s;
      op2_nxt_s = in_op2_sel ? in_imm : rs2val_s;
      sd_nxt_s  = rs2val_s;
    end else begin
      op1_nxt_s = op1;
      op2_nxt_s = op2;
      sd_nxt_s  = out_store_data;
    end
  end
`endif

  // Handshake state and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      stall_cnt <= {CNT_W{1'b0}};
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept_s) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (hold_s && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1            <= {XLEN{1'b0}};
      op2            <= {XLEN{1'b0}};
      out_store_data <= {XLEN{1'b0}};
      alu_op         <= 4'd0;
      out_pc         <= {XLEN{1'b0}};
      out_imm        <= {XLEN{1'b0}};
      out_rd_addr    <= 5'd0;
      out_rd_wen     <= 1'b0;
      out_br_type    <= 3'd0;
    end else begin
      op1            <= op1_nxt_s;
      op2            <= op2_nxt_s;
      out_store_data <= sd_nxt_s;
      if (accept_s) begin
        alu_op      <= in_alu_op;
        out_pc      <= in_pc;
        out_imm     <= in_imm;
        out_rd_addr <= in_rd_addr;
        out_rd_wen  <= in_rd_wen;
        out_br_type <= in_br_type;
      end
    end
  end

endmodule

// File: tb/tb_idex_operand_stage.sv
// Randomized bench for idex_operand_stage checked against a one-entry behavioural model.
module tb_idex_operand_stage;
  localparam int XL = 64;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [XL-1:0] in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic [4:0] in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
  logic in_op1_sel = 1'b0, in_op2_sel = 1'b0;
  logic [3:0] in_alu_op = '0;
  logic [2:0] in_br_type = '0;
  logic in_rd_wen = 1'b0, flush = 1'b0;
  logic wb_wen = 1'b0;
  logic [4:0] wb_rd = '0;
  logic [XL-1:0] wb_data = '0;
  logic out_valid, out_ready = 1'b0;
  logic [XL-1:0] op1, op2, out_pc, out_store_data, out_imm;
  logic [3:0] alu_op;
  logic [4:0] out_rd_addr;
  logic out_rd_wen;
  logic [2:0] out_br_type;
  logic [CW-1:0] stall_cnt;

  idex_operand_stage #(.XLEN(XL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel), .in_alu_op(in_alu_op),
    .in_br_type(in_br_type), .in_rd_wen(in_rd_wen), .flush(flush),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2), .alu_op(alu_op),
    .out_pc(out_pc), .out_store_data(out_store_data), .out_imm(out_imm),
    .out_rd_addr(out_rd_addr), .out_rd_wen(out_rd_wen), .out_br_type(out_br_type),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XL-1:0] op1, op2, pc, sd, imm;
    logic [3:0] alu;
    logic [4:0] rd, rs1, rs2;
    logic wen, sel1, sel2;
    logic [2:0] br;
  } entry_t;

  entry_t m;
  logic m_valid;
  logic [CW-1:0] m_cnt;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m = '{default: '0};
    m_valid = 1'b0;
    m_cnt = '0;
  endtask

  function automatic logic [XL-1:0] src(input logic [4:0] a, input logic [XL-1:0] d);
`ifdef IDEX_WB_FWD_EN
    if (wb_wen && a != 5'd0 && wb_rd == a) return wb_data;
`endif
    return d;
  endfunction

  // Model of one clock edge, from the stage's rules (occupancy of a one-deep slot)
  task automatic model_edge();
    logic [XL-1:0] r1, r2;
    if (m_valid && !out_ready && !flush && m_cnt != CMAX) m_cnt++;
    if (flush) begin
      m_valid = 1'b0;
    end else if (m_valid && !out_ready) begin
`ifdef IDEX_WB_FWD_EN
      if (wb_wen && wb_rd != 5'd0 && wb_rd == m.rs1 && !m.sel1) m.op1 = wb_data;
      if (wb_wen && wb_rd != 5'd0 && wb_rd == m.rs2) begin
        m.sd = wb_data;
        if (!m.sel2) m.op2 = wb_data;
      end
`endif
    end else if (in_valid) begin
      r1 = src(in_rs1_addr, in_rs1_data);
      r2 = src(in_rs2_addr, in_rs2_data);
      m.op1 = in_op1_sel ? in_pc : r1;
      m.op2 = in_op2_sel ? in_imm : r2;
      m.sd = r2; m.pc = in_pc; m.imm = in_imm; m.alu = in_alu_op;
      m.rd = in_rd_addr; m.wen = in_rd_wen; m.br = in_br_type;
      m.rs1 = in_rs1_addr; m.rs2 = in_rs2_addr; m.sel1 = in_op1_sel; m.sel2 = in_op2_sel;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_outputs(input logic all_fields);
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("stall_cnt", {60'd0, stall_cnt}, {60'd0, m_cnt});
    if (m_valid || all_fields) begin
      check("op1", op1, m.op1);
      check("op2", op2, m.op2);
      check("store_data", out_store_data, m.sd);
      check("pc", out_pc, m.pc);
      check("imm", out_imm, m.imm);
      check("alu_op", {60'd0, alu_op}, {60'd0, m.alu});
      check("rd", {59'd0, out_rd_addr}, {59'd0, m.rd});
      check("rd_wen", {63'd0, out_rd_wen}, {63'd0, m.wen});
      check("br_type", {61'd0, out_br_type}, {61'd0, m.br});
    end
  endtask

  // Called at a negedge with inputs already driven
  task automatic cyc();
    #1;
    check("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(1'b0);
    @(negedge clk);
  endtask

  task automatic rand_instr();
    in_pc = {$urandom(), $urandom()};
    in_rs1_data = {$urandom(), $urandom()};
    in_rs2_data = {$urandom(), $urandom()};
    in_imm = {$urandom(), $urandom()};
    in_rs1_addr = 5'($urandom_range(0, 3));
    in_rs2_addr = 5'($urandom_range(0, 3));
    in_rd_addr = 5'($urandom);
    in_op1_sel = 1'($urandom);
    in_op2_sel = 1'($urandom);
    in_alu_op = 4'($urandom);
    in_br_type = 3'($urandom);
    in_rd_wen = 1'($urandom);
    wb_wen = 1'($urandom);
    wb_rd = 5'($urandom_range(0, 3));
    wb_data = {$urandom(), $urandom()};
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs(1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Single accept with PC/immediate operands
    rand_instr();
    in_valid = 1'b1; out_ready = 1'b1; in_pc = 64'h8000_0000; in_imm = 64'h10;
    in_op1_sel = 1'b1; in_op2_sel = 1'b1; in_alu_op = 4'd0;
    cyc();
    check("plan_op1", op1, 64'h8000_0000);
    check("plan_op2", op2, 64'h10);

    // Back-to-back, then a 5-cycle stall with decode still presenting
    for (int i = 0; i < 3; i++) begin rand_instr(); cyc(); end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin rand_instr(); cyc(); end
    check("plan_stall5", {60'd0, stall_cnt}, 64'd5);
    out_ready = 1'b1; rand_instr(); cyc();

    // Flush while holding with an incoming instruction
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_instr(); cyc(); end
    flush = 1'b1; rand_instr(); cyc();
    check("plan_flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0;

`ifdef IDEX_WB_FWD_EN
    out_ready = 1'b1; rand_instr();
    in_rs1_addr = 5'd5; in_rs1_data = 64'h1; in_op1_sel = 1'b0;
    wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 64'hABCD;
    cyc();
    check("plan_fwd_hit", op1, 64'hABCD);
    in_rs1_addr = 5'd0; wb_rd = 5'd0;
    cyc();
    check("plan_fwd_x0", op1, 64'h1);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_instr();
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 9) == 0);
      cyc();
    end
    flush = 1'b0;

    // Saturation: long hold past the counter maximum
    in_valid = 1'b1; out_ready = 1'b1; rand_instr(); cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin rand_instr(); cyc(); end
    check("stall_saturate", {60'd0, stall_cnt}, {60'd0, CMAX});

    // Asynchronous reset in the middle of a hold
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_cnt", {60'd0, stall_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
